ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/fcpu_pkg.sv | 29 ++
 rtl/ifq_ring_ctrl.sv | 71 +++++++
 rtl/ifetch_queue.sv | 205 ++++++++++++++++++++
 tb/tb_ifetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths, opcodes and the instruction-fetch queue entry type.
//   CRAM_ADDR_W - code RAM byte address width
//   DATA_W      - fetched word width
//   INSTR_W     - instruction width
//   I_JMP       - opcode of the unconditional jump (top OPC_W bits of the word)
package fcpu_pkg;

    localparam int unsigned CRAM_ADDR_W = 16;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned OPC_W       = 8;

    localparam logic [OPC_W-1:0] I_JMP = 8'h1F;

    // One fetch-queue slot.
    typedef struct packed {
        logic [CRAM_ADDR_W-1:0] pc;
        logic [DATA_W-1:0]      data;
        logic                   filled;
        logic                   err;
        logic                   epoch;
    } ifq_entry_t;

    // Opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] inst);
        return inst[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/ifq_ring_ctrl.sv
// ifq_ring_ctrl: head/tail/fill pointers and occupancy counters of the fetch ring.
//   clk, nrst     - clock, async active-low reset
//   alloc_i       - allocate the tail slot (AR handshake)
//   fill_i        - fill the oldest unfilled slot (R beat)
//   pop_i         - release the head slot (must be filled)
//   head_o/tail_o/fill_ptr_o/count_o - current state
//   head_d_o/count_d_o              - next-state values for registered consumers
//   can_fill_o    - at least one allocated slot is still waiting for data
module ifq_ring_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     alloc_i,
    input  logic                     fill_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH)-1:0] head_o,
    output logic [$clog2(DEPTH)-1:0] head_d_o,
    output logic [$clog2(DEPTH)-1:0] tail_o,
    output logic [$clog2(DEPTH)-1:0] fill_ptr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_d_o,
    output logic                     can_fill_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] fptr_q, fptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] nfill_q, nfill_d;

    // Pointers wrap naturally since DEPTH is a power of two; count tells full from empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        fptr_d  = fptr_q;
        if (alloc_i) tail_d = tail_q + PTR_W'(1);
        if (pop_i)   head_d = head_q + PTR_W'(1);
        if (fill_i)  fptr_d = fptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
        nfill_d = nfill_q + CNT_W'(fill_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head_q  <= '0;
            tail_q  <= '0;
            fptr_q  <= '0;
            count_q <= '0;
            nfill_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fptr_q  <= fptr_d;
            count_q <= count_d;
            nfill_q <= nfill_d;
        end
    end

    assign head_o     = head_q;
    assign head_d_o   = head_d;
    assign tail_o     = tail_q;
    assign fill_ptr_o = fptr_q;
    assign count_o    = count_q;
    assign count_d_o  = count_d;
    assign can_fill_o = (count_q != nfill_q);

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: AXI4 read-only instruction prefetcher with an in-order epoch-tagged queue.
//   clk, nrst                  - clock, async active-low reset
//   redirect_valid/redirect_pc - flush queued fetches and restart at redirect_pc
//   s_cram_ar*                 - AXI read-address channel (single-beat 32-bit reads)
//   s_cram_r*                  - AXI read-data channel (rready tied high)
//   o_valid/o_pc/o_inst/o_err  - head instruction; i_ready pops it
// Build option: define IFETCH_JMP_FOLD_EN to redirect internally on fetched I_JMP words.
module ifetch_queue
    import fcpu_pkg::*;
#(
    parameter int unsigned            DEPTH    = 4,
    parameter logic [CRAM_ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned            PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   redirect_valid,
    input  logic [CRAM_ADDR_W-1:0] redirect_pc,
    output logic [31:0]            s_cram_araddr,
    output logic                   s_cram_arvalid,
    input  logic                   s_cram_arready,
    output logic [3:0]             s_cram_arid,
    output logic [7:0]             s_cram_arlen,
    output logic [2:0]             s_cram_arsize,
    output logic [1:0]             s_cram_arburst,
    output logic                   s_cram_arlock,
    output logic [3:0]             s_cram_arcache,
    output logic [2:0]             s_cram_arprot,
    output logic [3:0]             s_cram_arqos,
    output logic [3:0]             s_cram_arregion,
    input  logic [31:0]            s_cram_rdata,
    input  logic [1:0]             s_cram_rresp,
    input  logic                   s_cram_rvalid,
    output logic                   s_cram_rready,
    output logic                   o_valid,
    output logic [CRAM_ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0]      o_inst,
    output logic                   o_err,
    input  logic                   i_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifq_entry_t mem_q [DEPTH];
    ifq_entry_t mem_d [DEPTH];

    logic [CRAM_ADDR_W-1:0] araddr_q, araddr_d;
    logic                   arvalid_q, arvalid_d;
    logic                   epoch_q, epoch_d;
    logic                   o_valid_q, o_valid_d;
    logic [CRAM_ADDR_W-1:0] o_pc_q, o_pc_d;
    logic [DATA_W-1:0]      o_inst_q, o_inst_d;
    logic                   o_err_q, o_err_d;

    logic [PTR_W-1:0] head, head_d, tail, fill_ptr;
    logic [CNT_W-1:0] count, count_d;
    logic             can_fill;

    logic                   ar_hs, fill, pop, discard;
    logic                   fold, redir;
    logic [CRAM_ADDR_W-1:0] fold_pc, redir_pc;
    ifq_entry_t             head_e, nxt_e;
    logic [PTR_W-1:0]       off_i, off_fill;
`ifdef IFETCH_JMP_FOLD_EN
    ifq_entry_t             fill_e;
`endif

    ifq_ring_ctrl #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .nrst       (nrst),
        .alloc_i    (ar_hs),
        .fill_i     (fill),
        .pop_i      (pop),
        .head_o     (head),
        .head_d_o   (head_d),
        .tail_o     (tail),
        .fill_ptr_o (fill_ptr),
        .count_o    (count),
        .count_d_o  (count_d),
        .can_fill_o (can_fill)
    );

    // Handshake, fill, pop/discard and redirect decisions for this cycle.
    always_comb begin
        ar_hs   = arvalid_q && s_cram_arready;
        fill    = s_cram_rvalid && can_fill;
        head_e  = mem_q[head];
        discard = (count != '0) && head_e.filled && (head_e.epoch != epoch_q);
        pop     = (o_valid_q && i_ready) || discard;
        fold    = 1'b0;
        fold_pc = '0;
`ifdef IFETCH_JMP_FOLD_EN
        fill_e  = mem_q[fill_ptr];
        fold    = fill && !redirect_valid && (fill_e.epoch == epoch_q)
                  && (opcode_of(INSTR_W'(s_cram_rdata)) == I_JMP);
        fold_pc = s_cram_rdata[CRAM_ADDR_W-1:0];
`endif
        redir    = redirect_valid || fold;
        redir_pc = redirect_valid ? redirect_pc : fold_pc;
    end

    // Next queue contents, fetch address and registered head outputs.
    always_comb begin
        mem_d     = mem_q;
        epoch_d   = epoch_q;
        araddr_d  = araddr_q;
        off_i     = '0;
        off_fill  = fill_ptr - head;

        // On a redirect every live entry is re-tagged relative to the new epoch, so
        // back-to-back redirects cannot revive older stale entries. A folded jump keeps
        // itself and older current entries; an external redirect keeps nothing.
        if (redir) begin
            epoch_d = ~epoch_q;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off_i = PTR_W'(i) - head;
                if (fold && (off_i <= off_fill) && (mem_q[i].epoch == epoch_q)) begin
                    mem_d[i].epoch = ~epoch_q;
                end else begin
                    mem_d[i].epoch = epoch_q;
                end
            end
        end

        if (fill) begin
            mem_d[fill_ptr].data   = s_cram_rdata;
            mem_d[fill_ptr].err    = (s_cram_rresp != 2'b00);
            mem_d[fill_ptr].filled = 1'b1;
        end

        if (pop) begin
            mem_d[head].filled = 1'b0;
        end

        // Old epoch on allocation: a request issued alongside a redirect is stale.
        if (ar_hs) begin
            mem_d[tail].pc     = araddr_q;
            mem_d[tail].data   = '0;
            mem_d[tail].filled = 1'b0;
            mem_d[tail].err    = 1'b0;
            mem_d[tail].epoch  = epoch_q;
        end

        if (redir) begin
            araddr_d = redir_pc;
        end else if (ar_hs) begin
            araddr_d = araddr_q + CRAM_ADDR_W'(PC_STEP);
        end

        // One-cycle bubble after a redirect; never request beyond the free slots.
        arvalid_d = !redir && (count_d < CNT_W'(DEPTH));

        nxt_e     = mem_d[head_d];
        o_valid_d = (count_d != '0) && nxt_e.filled && (nxt_e.epoch == epoch_d);
        o_pc_d    = nxt_e.pc;
        o_inst_d  = nxt_e.data;
        o_err_d   = nxt_e.filled && nxt_e.err;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            araddr_q  <= RESET_PC;
            arvalid_q <= 1'b0;
            epoch_q   <= 1'b0;
            o_valid_q <= 1'b0;
            o_pc_q    <= '0;
            o_inst_q  <= '0;
            o_err_q   <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            epoch_q   <= epoch_d;
            o_valid_q <= o_valid_d;
            o_pc_q    <= o_pc_d;
            o_inst_q  <= o_inst_d;
            o_err_q   <= o_err_d;
        end
    end

    assign s_cram_araddr   = 32'(araddr_q);
    assign s_cram_arvalid  = arvalid_q;
    assign s_cram_arid     = 4'd0;
    assign s_cram_arlen    = 8'd0;
    assign s_cram_arsize   = 3'd2;
    assign s_cram_arburst  = 2'd1;
    assign s_cram_arlock   = 1'b0;
    assign s_cram_arcache  = 4'd0;
    assign s_cram_arprot   = 3'd0;
    assign s_cram_arqos    = 4'd0;
    assign s_cram_arregion = 4'd0;
    assign s_cram_rready   = 1'b1;

    assign o_valid = o_valid_q;
    assign o_pc    = o_pc_q;
    assign o_inst  = o_inst_q;
    assign o_err   = o_err_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue with a 1-cycle AXI memory model.
module tb_ifetch_queue;
    import fcpu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   nrst;
    logic                   redirect_valid;
    logic [CRAM_ADDR_W-1:0] redirect_pc;
    logic [31:0]            s_cram_araddr;
    logic                   s_cram_arvalid;
    logic                   s_cram_arready;
    logic [3:0]             s_cram_arid;
    logic [7:0]             s_cram_arlen;
    logic [2:0]             s_cram_arsize;
    logic [1:0]             s_cram_arburst;
    logic                   s_cram_arlock;
    logic [3:0]             s_cram_arcache;
    logic [2:0]             s_cram_arprot;
    logic [3:0]             s_cram_arqos;
    logic [3:0]             s_cram_arregion;
    logic [31:0]            s_cram_rdata;
    logic [1:0]             s_cram_rresp;
    logic                   s_cram_rvalid;
    logic                   s_cram_rready;
    logic                   o_valid;
    logic [CRAM_ADDR_W-1:0] o_pc;
    logic [DATA_W-1:0]      o_inst;
    logic                   o_err;
    logic                   i_ready;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC ('0),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .s_cram_araddr   (s_cram_araddr),
        .s_cram_arvalid  (s_cram_arvalid),
        .s_cram_arready  (s_cram_arready),
        .s_cram_arid     (s_cram_arid),
        .s_cram_arlen    (s_cram_arlen),
        .s_cram_arsize   (s_cram_arsize),
        .s_cram_arburst  (s_cram_arburst),
        .s_cram_arlock   (s_cram_arlock),
        .s_cram_arcache  (s_cram_arcache),
        .s_cram_arprot   (s_cram_arprot),
        .s_cram_arqos    (s_cram_arqos),
        .s_cram_arregion (s_cram_arregion),
        .s_cram_rdata    (s_cram_rdata),
        .s_cram_rresp    (s_cram_rresp),
        .s_cram_rvalid   (s_cram_rvalid),
        .s_cram_rready   (s_cram_rready),
        .o_valid         (o_valid),
        .o_pc            (o_pc),
        .o_inst          (o_inst),
        .o_err           (o_err),
        .i_ready         (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CRAM_ADDR_W-1:0] pc;
        logic [DATA_W-1:0]      inst;
        logic                   err;
    } exp_t;

    exp_t                   exp_q[$];
    logic [CRAM_ADDR_W-1:0] mem_q[$];
    logic [31:0]            ar_log[$];
    logic [31:0]            pop_log[$];

    int unsigned            n_tests = 0;
    int unsigned            n_fail  = 0;
    int unsigned            n_hs;
    int unsigned            inflight;
    logic                   mem_en;
    logic                   jmp_en  = 1'b0;
    logic                   sb_en   = 1'b1;
    logic [CRAM_ADDR_W-1:0] err_addr = CRAM_ADDR_W'(8);
    logic [CRAM_ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0]      hold_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [CRAM_ADDR_W-1:0] a);
        if (jmp_en && (a == CRAM_ADDR_W'(4))) return {I_JMP, 8'h00, 16'h0040};
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Negedge observer: pops are compared first, a redirect then drops all queued
    // expectations, and only AR handshakes outside a redirect cycle are expected later.
    task automatic monitor();
        exp_t e;
        if (o_valid && i_ready) begin
            pop_log.push_back(32'(o_pc));
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", 32'(o_pc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("o_pc",   32'(o_pc),   32'(e.pc));
                    check("o_inst", 32'(o_inst), 32'(e.inst));
                    check("o_err",  32'(o_err),  32'(e.err));
                end
            end
        end
        if (redirect_valid) exp_q.delete();
        if (s_cram_arvalid && s_cram_arready) begin
            check("ar_inflight_lt_depth", 32'(inflight < DEPTH), 32'd1);
            inflight++;
            n_hs++;
            ar_log.push_back(s_cram_araddr);
            mem_q.push_back(s_cram_araddr[CRAM_ADDR_W-1:0]);
            if (!redirect_valid) begin
                exp_q.push_back('{pc:   s_cram_araddr[CRAM_ADDR_W-1:0],
                                  inst: mem_word(s_cram_araddr[CRAM_ADDR_W-1:0]),
                                  err:  (s_cram_araddr[CRAM_ADDR_W-1:0] == err_addr)});
            end
        end
        if (s_cram_rvalid) begin
            void'(mem_q.pop_front());
            inflight--;
        end
    endtask

    task automatic drive_r();
        logic [CRAM_ADDR_W-1:0] a;
        if (mem_en && (mem_q.size() > 0)) begin
            a             = mem_q[0];
            s_cram_rvalid = 1'b1;
            s_cram_rdata  = mem_word(a);
            s_cram_rresp  = (a == err_addr) ? 2'd2 : 2'd0;
        end else begin
            s_cram_rvalid = 1'b0;
            s_cram_rdata  = '0;
            s_cram_rresp  = '0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive_r();
    endtask

    // Asynchronous reset mid-operation; in-flight reads are abandoned with the fabric.
    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check("rst_arvalid", 32'(s_cram_arvalid), 32'd0);
        check("rst_araddr",  s_cram_araddr,       32'd0);
        check("rst_o_valid", 32'(o_valid),        32'd0);
        check("rst_o_err",   32'(o_err),          32'd0);
        check("rst_o_pc",    32'(o_pc),           32'd0);
        check("rst_o_inst",  32'(o_inst),         32'd0);
        redirect_valid = 1'b0;
        s_cram_arready = 1'b0;
        i_ready        = 1'b0;
        mem_en         = 1'b0;
        s_cram_rvalid  = 1'b0;
        s_cram_rdata   = '0;
        s_cram_rresp   = '0;
        exp_q.delete();
        mem_q.delete();
        ar_log.delete();
        pop_log.delete();
        inflight = 0;
        n_hs     = 0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        nrst           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        s_cram_arready = 1'b0;
        s_cram_rvalid  = 1'b0;
        s_cram_rdata   = '0;
        s_cram_rresp   = '0;
        i_ready        = 1'b0;
        mem_en         = 1'b0;
        #2;

        // Reset state and constant AR/R fields.
        do_reset();
        check("arid",    32'(s_cram_arid),    32'd0);
        check("arlen",   32'(s_cram_arlen),   32'd0);
        check("arsize",  32'(s_cram_arsize),  32'd2);
        check("arburst", 32'(s_cram_arburst), 32'd1);
        check("arother", 32'({s_cram_arlock, s_cram_arcache, s_cram_arprot,
                              s_cram_arqos, s_cram_arregion}), 32'd0);
        check("rready",  32'(s_cram_rready),  32'd1);

        // Streaming after reset; pc 8 returns SLVERR.
        s_cram_arready = 1'b1;
        mem_en         = 1'b1;
        i_ready        = 1'b1;
        step();
        check("arvalid_after_reset", 32'(s_cram_arvalid), 32'd1);
        repeat (20) step();
        for (int i = 0; i < 4; i++) begin
            check("stream_araddr", (ar_log.size() > i) ? ar_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
        end
        for (int i = 0; i < 3; i++) begin
            check("stream_o_pc", (pop_log.size() > i) ? pop_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
        end

        // Memory stalled: exactly DEPTH requests, then arvalid low until a pop.
        do_reset();
        s_cram_arready = 1'b1;
        i_ready        = 1'b1;
        repeat (12) step();
        check("stall_hs_count", 32'(n_hs), 32'(DEPTH));
        check("stall_arvalid",  32'(s_cram_arvalid), 32'd0);
        check("stall_o_valid",  32'(o_valid), 32'd0);
        mem_en = 1'b1;
        for (int i = 0; i < 20 && n_hs <= DEPTH; i++) step();
        check("stall_resume", 32'(n_hs > DEPTH), 32'd1);
        repeat (10) step();

        // Consumer back-pressure: head holds, no extra requests.
        do_reset();
        s_cram_arready = 1'b1;
        mem_en         = 1'b1;
        repeat (4) step();
        check("hold_o_valid", 32'(o_valid), 32'd1);
        check("hold_o_pc0",   32'(o_pc),    32'd0);
        hold_pc   = o_pc;
        hold_inst = o_inst;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_o_pc",   32'(o_pc),   32'(hold_pc));
            check("hold_o_inst", 32'(o_inst), 32'(hold_inst));
        end
        check("hold_hs_count", 32'(n_hs), 32'(DEPTH));
        i_ready = 1'b1;
        repeat (15) step();

        // Redirect with three reads outstanding.
        do_reset();
        s_cram_arready = 1'b1;
        i_ready        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (n_hs >= 3) break;
        end
        s_cram_arready = 1'b0;
        check("redir_inflight", 32'(n_hs), 32'd3);
        redirect_pc    = CRAM_ADDR_W'(16'h0100);
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        s_cram_arready = 1'b1;
        mem_en         = 1'b1;
        pop_log.delete();
        repeat (15) step();
        check("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h0100);

        // Randomised traffic with occasional redirects, then drain.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s_cram_arready = ($urandom_range(0, 3) != 0);
            mem_en         = ($urandom_range(0, 9) < 7);
            i_ready        = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = CRAM_ADDR_W'($urandom_range(0, 1023) * 4);
            step();
        end
        redirect_valid = 1'b0;
        s_cram_arready = 1'b0;
        mem_en         = 1'b1;
        i_ready        = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || inflight != 0); i++) step();
        check("drain_exp_left", 32'(exp_q.size()), 32'd0);
        check("drain_inflight", 32'(inflight),     32'd0);

`ifdef IFETCH_JMP_FOLD_EN
        // Folded jump at pc 4 to 0x40; pc 8 must never appear.
        do_reset();
        jmp_en         = 1'b1;
        sb_en          = 1'b0;
        s_cram_arready = 1'b1;
        mem_en         = 1'b1;
        i_ready        = 1'b1;
        repeat (20) step();
        check("fold_pc0", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h0000);
        check("fold_pc1", (pop_log.size() > 1) ? pop_log[1] : 32'hFFFF_FFFF, 32'h0004);
        check("fold_pc2", (pop_log.size() > 2) ? pop_log[2] : 32'hFFFF_FFFF, 32'h0040);
        jmp_en = 1'b0;
        sb_en  = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
